hs32_decode_q: RTL and testbench

- Parametrised successor to the HS32 decode stage. Decodes fetched instruction words into explicit execute-stage fields.
- Decoded entries are buffered in a small queue, with valid/ready flow control toward execute and the existing reqd/ackd handshake toward fetch.
- Adds a flush input for branches and exceptions, and illegal-opcode detection.
- Sits between hs32_fetch and hs32_exec.

---
 rtl/hs32_decode_q.sv | 244 ++++++++++++++++++++++++
 tb/tb_hs32_decode_q.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_decode_q.sv
// rtl/hs32_decode_q.sv - HS32 decode stage with decoded-entry queue (optional HS32_DECODE_STATS_EN counters)
module hs32_decode_q #(
    parameter int IMM_WIDTH = 16,
    parameter int REG_BITS  = 4,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instd,
    input  logic                 ackd,
    output logic                 reqd,
    input  logic                 flush,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [3:0]           aluop,
    output logic [4:0]           shift,
    output logic [1:0]           shdir,
    output logic [1:0]           bank,
    output logic [IMM_WIDTH-1:0] imm,
    output logic [REG_BITS-1:0]  rd,
    output logic [REG_BITS-1:0]  rm,
    output logic [REG_BITS-1:0]  rn,
    output logic [1:0]           memop,
    output logic [1:0]           bsel,
    output logic                 wb,
    output logic                 illegal
`ifdef HS32_DECODE_STATS_EN
    ,
    output logic [31:0]          stat_dec,
    output logic [31:0]          stat_ill
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Opcode encodings (instd[31:24])
    localparam logic [7:0] OP_LDRI = 8'h10;
    localparam logic [7:0] OP_LDR  = 8'h14;
    localparam logic [7:0] OP_LDRA = 8'h15;
    localparam logic [7:0] OP_STRI = 8'h30;
    localparam logic [7:0] OP_STR  = 8'h34;
    localparam logic [7:0] OP_STRA = 8'h35;
    localparam logic [7:0] OP_MOVN = 8'h20;
    localparam logic [7:0] OP_MOVI = 8'h24;
    localparam logic [7:0] OP_MOVR = 8'h25;

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_MOV = 4'hA;
    localparam logic [3:0] ALU_NOP = 4'hF;

    // Operand-B source and memory operation encodings
    localparam logic [1:0] BSEL_ZERO = 2'b00;
    localparam logic [1:0] BSEL_IMM  = 2'b01;
    localparam logic [1:0] BSEL_SHRN = 2'b10;
    localparam logic [1:0] BSEL_RM   = 2'b11;
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    typedef struct packed {
        logic [3:0]           aluop;
        logic [4:0]           shift;
        logic [1:0]           shdir;
        logic [1:0]           bank;
        logic [IMM_WIDTH-1:0] imm;
        logic [REG_BITS-1:0]  rd;
        logic [REG_BITS-1:0]  rm;
        logic [REG_BITS-1:0]  rn;
        logic [1:0]           memop;
        logic [1:0]           bsel;
        logic                 wb;
        logic                 illegal;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

    occ_t             occ_q, occ_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    entry_t           dec;
    entry_t           head;
    logic             push;
    logic             pop;

`ifdef HS32_DECODE_STATS_EN
    logic [31:0] stat_dec_q, stat_dec_d;
    logic [31:0] stat_ill_q, stat_ill_d;
`endif

    // Decode the incoming word into execute-stage fields; only register-sourced B operands carry a shift
    always_comb begin
        dec         = '0;
        dec.aluop   = ALU_NOP;
        dec.memop   = MEM_NONE;
        dec.bsel    = BSEL_ZERO;
        dec.rd      = instd[20 +: REG_BITS];
        dec.rm      = instd[16 +: REG_BITS];
        dec.rn      = instd[12 +: REG_BITS];
        dec.shdir   = instd[10:9];
        dec.bank    = instd[8:7];
        case (instd[31:24])
            OP_LDRI: begin dec.aluop = ALU_ADD; dec.bsel = BSEL_IMM;  dec.memop = MEM_LOAD;  dec.wb = 1'b1; end
            OP_LDR:  begin dec.aluop = ALU_ADD; dec.bsel = BSEL_ZERO; dec.memop = MEM_LOAD;  dec.wb = 1'b1; end
            OP_LDRA: begin dec.aluop = ALU_ADD; dec.bsel = BSEL_SHRN; dec.memop = MEM_LOAD;  dec.wb = 1'b1; end
            OP_STRI: begin dec.aluop = ALU_ADD; dec.bsel = BSEL_IMM;  dec.memop = MEM_STORE; end
            OP_STR:  begin dec.aluop = ALU_ADD; dec.bsel = BSEL_ZERO; dec.memop = MEM_STORE; end
            OP_STRA: begin dec.aluop = ALU_ADD; dec.bsel = BSEL_SHRN; dec.memop = MEM_STORE; end
            OP_MOVI: begin dec.aluop = ALU_MOV; dec.bsel = BSEL_IMM;  dec.wb = 1'b1; end
            OP_MOVN: begin dec.aluop = ALU_MOV; dec.bsel = BSEL_SHRN; dec.wb = 1'b1; end
            OP_MOVR: begin dec.aluop = ALU_MOV; dec.bsel = BSEL_RM;   dec.wb = 1'b1; end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.bsel == BSEL_IMM) begin
            dec.imm = instd[IMM_WIDTH-1:0];
        end
        if (dec.bsel[1]) begin
            dec.shift = instd[15:11];
        end
    end

    // Handshake qualifiers; flush suppresses both push and pop
    always_comb begin
        push = ackd && reqd && !flush;
        pop  = valid_o && ready_i && !flush;
    end

    // Queue bookkeeping and occupancy state transitions
    always_comb begin
        occ_d    = occ_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            occ_d    = OCC_EMPTY;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            case (occ_q)
                OCC_EMPTY: begin
                    if (push) occ_d = OCC_PARTIAL;
                end
                OCC_PARTIAL: begin
                    if (push && !pop && count_q == CNT_W'(DEPTH - 1)) begin
                        occ_d = OCC_FULL;
                    end else if (pop && !push && count_q == CNT_W'(1)) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) occ_d = OCC_PARTIAL;
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

`ifdef HS32_DECODE_STATS_EN
    // Accept counters survive flush and wrap naturally
    always_comb begin
        stat_dec_d = stat_dec_q;
        stat_ill_d = stat_ill_q;
        if (push) begin
            stat_dec_d = stat_dec_q + 32'd1;
            if (dec.illegal) begin
                stat_ill_d = stat_ill_q + 32'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_dec_q <= '0;
            stat_ill_q <= '0;
        end else begin
            stat_dec_q <= stat_dec_d;
            stat_ill_q <= stat_ill_d;
        end
    end

    assign stat_dec = stat_dec_q;
    assign stat_ill = stat_ill_q;
`endif

    // Queue state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q    <= OCC_EMPTY;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            occ_q    <= occ_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Outputs come only from registered queue state
    always_comb begin
        head    = mem_q[rd_ptr_q];
        reqd    = (occ_q != OCC_FULL);
        valid_o = (occ_q != OCC_EMPTY);
        aluop   = head.aluop;
        shift   = head.shift;
        shdir   = head.shdir;
        bank    = head.bank;
        imm     = head.imm;
        rd      = head.rd;
        rm      = head.rm;
        rn      = head.rn;
        memop   = head.memop;
        bsel    = head.bsel;
        wb      = head.wb;
        illegal = head.illegal;
    end

endmodule

// File: tb/tb_hs32_decode_q.sv
// tb/tb_hs32_decode_q.sv - scoreboard testbench for hs32_decode_q
module tb_hs32_decode_q;

    localparam int DEPTH = 2;

    localparam logic [7:0] OP_LDRI = 8'h10;
    localparam logic [7:0] OP_LDR  = 8'h14;
    localparam logic [7:0] OP_LDRA = 8'h15;
    localparam logic [7:0] OP_STRI = 8'h30;
    localparam logic [7:0] OP_STR  = 8'h34;
    localparam logic [7:0] OP_STRA = 8'h35;
    localparam logic [7:0] OP_MOVN = 8'h20;
    localparam logic [7:0] OP_MOVI = 8'h24;
    localparam logic [7:0] OP_MOVR = 8'h25;
    localparam logic [3:0] A_ADD = 4'h0;
    localparam logic [3:0] A_MOV = 4'hA;
    localparam logic [3:0] A_NOP = 4'hF;

    typedef struct packed {
        logic [3:0]  aluop;
        logic [4:0]  shift;
        logic [1:0]  shdir;
        logic [1:0]  bank;
        logic [15:0] imm;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rn;
        logic [1:0]  memop;
        logic [1:0]  bsel;
        logic        wb;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, ackd, flush, ready_i;
    logic [31:0] instd;
    logic        reqd, valid_o;
    logic [3:0]  aluop;
    logic [4:0]  shift;
    logic [1:0]  shdir, bank, memop, bsel;
    logic [15:0] imm;
    logic [3:0]  rd, rm, rn;
    logic        wb, illegal;
`ifdef HS32_DECODE_STATS_EN
    logic [31:0] stat_dec, stat_ill;
`endif

    exp_t        sq[$];
    exp_t        dut_e;
    logic [31:0] s_dec, s_ill;
    int          checks   = 0;
    int          failures = 0;
    logic        mon_en   = 1'b0;

    always #5 clk = ~clk;

    hs32_decode_q #(.IMM_WIDTH(16), .REG_BITS(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .instd(instd), .ackd(ackd), .reqd(reqd),
        .flush(flush), .valid_o(valid_o), .ready_i(ready_i),
        .aluop(aluop), .shift(shift), .shdir(shdir), .bank(bank), .imm(imm),
        .rd(rd), .rm(rm), .rn(rn), .memop(memop), .bsel(bsel), .wb(wb),
        .illegal(illegal)
`ifdef HS32_DECODE_STATS_EN
        , .stat_dec(stat_dec), .stat_ill(stat_ill)
`endif
    );

    assign dut_e = {aluop, shift, shdir, bank, imm, rd, rm, rn, memop, bsel, wb, illegal};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode built from the instruction-form table
    function automatic exp_t model(input logic [31:0] i);
        exp_t e;
        e       = '0;
        e.aluop = A_NOP;
        e.rd    = i[23:20];
        e.rm    = i[19:16];
        e.rn    = i[15:12];
        e.shdir = i[10:9];
        e.bank  = i[8:7];
        case (i[31:24])
            OP_LDRI: begin e.aluop = A_ADD; e.bsel = 2'b01; e.memop = 2'b01; e.wb = 1'b1; end
            OP_LDR:  begin e.aluop = A_ADD; e.bsel = 2'b00; e.memop = 2'b01; e.wb = 1'b1; end
            OP_LDRA: begin e.aluop = A_ADD; e.bsel = 2'b10; e.memop = 2'b01; e.wb = 1'b1; end
            OP_STRI: begin e.aluop = A_ADD; e.bsel = 2'b01; e.memop = 2'b10; end
            OP_STR:  begin e.aluop = A_ADD; e.bsel = 2'b00; e.memop = 2'b10; end
            OP_STRA: begin e.aluop = A_ADD; e.bsel = 2'b10; e.memop = 2'b10; end
            OP_MOVI: begin e.aluop = A_MOV; e.bsel = 2'b01; e.wb = 1'b1; end
            OP_MOVN: begin e.aluop = A_MOV; e.bsel = 2'b10; e.wb = 1'b1; end
            OP_MOVR: begin e.aluop = A_MOV; e.bsel = 2'b11; e.wb = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        if (e.bsel == 2'b01) e.imm = i[15:0];
        if (e.bsel == 2'b10 || e.bsel == 2'b11) e.shift = i[15:11];
        return e;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [7:0] ops [9];
        logic [7:0] op;
        ops = '{OP_LDRI, OP_LDR, OP_LDRA, OP_STRI, OP_STR, OP_STRA, OP_MOVN, OP_MOVI, OP_MOVR};
        if ($urandom_range(0, 4) == 0) op = 8'($urandom);
        else op = ops[$urandom_range(0, 8)];
        return {op, 24'($urandom)};
    endfunction

    // Apply one cycle of stimulus and record the expected queue effect at the edge
    task automatic drive(input logic rst, input logic a, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        int   n;
        exp_t e;
        reset   = rst;
        ackd    = a;
        instd   = ins;
        ready_i = rdy;
        flush   = fl;
        @(posedge clk);
        if (rst) begin
            sq.delete();
            s_dec = '0;
            s_ill = '0;
        end else if (fl) begin
            sq.delete();
        end else begin
            n = sq.size();
            if (n > 0 && rdy) sq.delete(0);
            if (a && n != DEPTH) begin
                e = model(ins);
                sq.push_back(e);
                s_dec = s_dec + 32'd1;
                if (e.ill) s_ill = s_ill + 32'd1;
            end
        end
        #2;
    endtask

    // Monitor: compare DUT head and flow control against the scoreboard every cycle
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("valid_o", valid_o, sq.size() != 0);
                chk("reqd", reqd, sq.size() != DEPTH);
                if (sq.size() != 0) chk("head_fields", dut_e, sq[0]);
`ifdef HS32_DECODE_STATS_EN
                chk("stat_dec", stat_dec, s_dec);
                chk("stat_ill", stat_ill, s_ill);
`endif
            end
        end
    end

    initial begin
        s_dec = '0;
        s_ill = '0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        mon_en = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("reset_fields", dut_e, 64'h0);
        chk("reset_valid", valid_o, 1'b0);
        chk("reset_reqd", reqd, 1'b1);

        // MOVI rd=3 imm=0x1234
        drive(1'b0, 1'b1, {OP_MOVI, 4'd3, 4'd0, 16'h1234}, 1'b1, 1'b0);
        chk("movi_valid", valid_o, 1'b1);
        chk("movi_rd", rd, 4'd3);
        chk("movi_imm", imm, 16'h1234);
        chk("movi_bsel", bsel, 2'b01);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Fill with ready low, third offer refused, then pop-only while full
        drive(1'b0, 1'b1, {OP_MOVR, 24'h123456}, 1'b0, 1'b0);
        drive(1'b0, 1'b1, {OP_LDRI, 24'h45ABCD}, 1'b0, 1'b0);
        chk("full_reqd", reqd, 1'b0);
        drive(1'b0, 1'b1, {OP_STRI, 24'h789ABC}, 1'b0, 1'b0);
        chk("full_still_two", valid_o, 1'b1);
        drive(1'b0, 1'b1, {OP_STRI, 24'h789ABC}, 1'b1, 1'b0);
        chk("pop_only_reqd", reqd, 1'b1);
        drive(1'b0, 1'b1, {OP_STRI, 24'h789ABC}, 1'b1, 1'b0);
        chk("third_at_head_imm", imm, 16'h9ABC);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // STRA rm=2, shift=7, shdir=01
        drive(1'b0, 1'b1, {OP_STRA, 4'd1, 4'd2, 5'd7, 2'b01, 2'b10, 7'h0}, 1'b1, 1'b0);
        chk("stra_memop", memop, 2'b10);
        chk("stra_shift", shift, 5'd7);
        chk("stra_shdir", shdir, 2'b01);
        drive(1'b0, 1'b1, 32'hFF12_3456, 1'b1, 1'b0);
        chk("ill_flag", illegal, 1'b1);
        chk("ill_aluop", aluop, A_NOP);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Two queued, then flush with a coincident ackd
        drive(1'b0, 1'b1, {OP_LDR, 24'h111111}, 1'b0, 1'b0);
        drive(1'b0, 1'b1, {OP_LDRA, 24'h222222}, 1'b0, 1'b0);
        drive(1'b0, 1'b1, {OP_MOVN, 24'h333333}, 1'b0, 1'b1);
        chk("flush_valid", valid_o, 1'b0);
        chk("flush_reqd", reqd, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), rand_ins(),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
